fsk_demod_ctrl: RTL

- Sequencing controller for the FSK peak-detection demodulator path.
- Takes the 8-bit sampled FSK waveform with a sample strobe and counts waveform peaks over fixed bit windows.
- Decides each window as mark (1) or space (0), frames the bit stream as start + 8 data + stop, and hands completed bytes downstream over a valid/ready handshake.
- Replaces the free-running single-count decision with timed, framed, flow-controlled output.

---
 rtl/fsk_demod_ctrl_if.sv | 27 ++
 rtl/fsk_demod_ctrl.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/fsk_demod_ctrl_if.sv
`default_nettype none
// ============================================================================
// fsk_demod_ctrl_if : sample input, bit/byte outputs and byte handshake bundle
// Rev 1.0
// ============================================================================
interface fsk_demod_ctrl_if;
   logic       sample_valid;
   logic [7:0] data_in;
   logic       bit_out;
   logic       bit_valid;
   logic [7:0] byte_out;
   logic       byte_valid;
   logic       byte_ready;
   logic       frame_err;
   logic       overrun;

   modport master (
      input  sample_valid, data_in, byte_ready,
      output bit_out, bit_valid, byte_out, byte_valid, frame_err, overrun
   );

   modport slave (
      output sample_valid, data_in, byte_ready,
      input  bit_out, bit_valid, byte_out, byte_valid, frame_err, overrun
   );
endinterface
`default_nettype wire

// File: rtl/fsk_demod_ctrl.sv
`default_nettype none
// ============================================================================
// fsk_demod_ctrl : windowed FSK peak counter, UART-style framer, byte handshake
// Rev 1.0
// ============================================================================
module fsk_demod_ctrl #(
   parameter int SAMPLES_PER_BIT = 32,
   parameter int PEAK_THRESH     = 6,
   parameter int CNT_W           = 6,
   parameter int ENERGY_MIN      = 160
) (
   input  wire logic         clk,
   input  wire logic         rst_n,
   input  wire logic         en,
   fsk_demod_ctrl_if.master  bus
);
   localparam logic [CNT_W-1:0] c_cnt_max = '1;
   localparam logic [CNT_W-1:0] c_last    = CNT_W'(SAMPLES_PER_BIT - 1);
   localparam logic [CNT_W-1:0] c_thresh  = CNT_W'(PEAK_THRESH);
   localparam logic [7:0]       c_energy  = 8'(ENERGY_MIN);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HUNT = 2'd1,
      ST_DATA = 2'd2,
      ST_STOP = 2'd3
   } state_t;

   state_t           r_state, w_state_nxt;
   logic [7:0]       r_prev;
   logic             r_rising;
   logic [CNT_W-1:0] r_peak_cnt, r_sample_cnt, w_peak_total;
   logic [2:0]       r_bit_idx;
   logic [7:0]       r_shift;
   logic             r_bit_out, r_bit_valid, r_frame_err, r_overrun;
   logic [7:0]       r_byte_out;
   logic             r_byte_valid;
   logic             w_adv, w_peak, w_last, w_decide, w_bit, w_deliver, w_frame_bad;

   assign w_adv  = en && bus.sample_valid;
   // A falling sample after a rise marks the previous sample as a peak.
   assign w_peak = r_rising && (bus.data_in < r_prev) && (r_prev >= c_energy);
   assign w_peak_total = (w_peak && (r_peak_cnt != c_cnt_max)) ? r_peak_cnt + 1'b1 : r_peak_cnt;
   assign w_last      = (r_sample_cnt == c_last);
   assign w_decide    = w_adv && w_last;
   assign w_bit       = (w_peak_total >= c_thresh);
   assign w_deliver   = w_decide && (r_state == ST_STOP) && w_bit;
   assign w_frame_bad = w_decide && (r_state == ST_STOP) && !w_bit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   r_state <= ST_IDLE;
      else if (!en) r_state <= ST_IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (w_decide) begin
         case (r_state)
            ST_IDLE: if (w_bit)  w_state_nxt = ST_HUNT;
            ST_HUNT: if (!w_bit) w_state_nxt = ST_DATA;
            ST_DATA: if (r_bit_idx == 3'd7) w_state_nxt = ST_STOP;
            ST_STOP: w_state_nxt = w_bit ? ST_HUNT : ST_IDLE;
            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_prev       <= '0;
         r_rising     <= 1'b0;
         r_peak_cnt   <= '0;
         r_sample_cnt <= '0;
         r_bit_idx    <= '0;
         r_shift      <= '0;
         r_bit_out    <= 1'b0;
         r_bit_valid  <= 1'b0;
         r_frame_err  <= 1'b0;
      end else if (!en) begin
         r_prev       <= '0;
         r_rising     <= 1'b0;
         r_peak_cnt   <= '0;
         r_sample_cnt <= '0;
         r_bit_idx    <= '0;
         r_shift      <= '0;
         r_bit_out    <= 1'b0;
         r_bit_valid  <= 1'b0;
         r_frame_err  <= 1'b0;
      end else begin
         r_bit_valid <= w_decide;
         r_frame_err <= w_frame_bad;
         if (w_adv) begin
            r_prev <= bus.data_in;
            if (bus.data_in > r_prev)      r_rising <= 1'b1;
            else if (bus.data_in < r_prev) r_rising <= 1'b0;
            if (w_last) begin
               r_sample_cnt <= '0;
               r_peak_cnt   <= '0;
               r_bit_out    <= w_bit;
            end else begin
               if (r_sample_cnt != c_cnt_max) r_sample_cnt <= r_sample_cnt + 1'b1;
               r_peak_cnt <= w_peak_total;
            end
         end
         if (w_decide) begin
            case (r_state)
               ST_HUNT: if (!w_bit) r_bit_idx <= '0;
               ST_DATA: begin
                  r_shift[r_bit_idx] <= w_bit;
                  r_bit_idx          <= r_bit_idx + 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

   // Byte holding register survives en low so a pending byte is not lost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_byte_out   <= '0;
         r_byte_valid <= 1'b0;
         r_overrun    <= 1'b0;
      end else begin
         r_overrun <= w_deliver && r_byte_valid && !bus.byte_ready;
         if (w_deliver && (!r_byte_valid || bus.byte_ready)) begin
            r_byte_out   <= r_shift;
            r_byte_valid <= 1'b1;
         end else if (r_byte_valid && bus.byte_ready) begin
            r_byte_valid <= 1'b0;
         end
      end
   end

   assign bus.bit_out    = r_bit_out;
   assign bus.bit_valid  = r_bit_valid;
   assign bus.byte_out   = r_byte_out;
   assign bus.byte_valid = r_byte_valid;
   assign bus.frame_err  = r_frame_err;
   assign bus.overrun    = r_overrun;
endmodule
`default_nettype wire
